// File: rtl/lcd_result_writer_if.sv
// Request/status handshake and HD44780 pin bundle for lcd_result_writer.
// The controller side uses the master modport, the LCD writer uses the slave modport.
interface lcd_result_writer_if;
    logic       start;
    logic [5:0] value;
    logic       busy;
    logic       done;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;

    modport master (output start, value,
                    input  busy, done, lcd_rs, lcd_rw, lcd_e, lcd_data);
    modport slave  (input  start, value,
                    output busy, done, lcd_rs, lcd_rw, lcd_e, lcd_data);
endinterface

// File: rtl/lcd_result_writer.sv
// Shows a 6-bit result as two decimal digits on an HD44780 LCD (8-bit, write-only).
// Define LCD_PREFIX_EN to print "R=" before the digits.
module lcd_result_writer #(
    parameter int INIT_WAIT_CYC  = 750000,
    parameter int SETUP_CYC      = 2,
    parameter int E_PULSE_CYC    = 12,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 100000
) (
    input logic                clk,
    input logic                rst,
    lcd_result_writer_if.slave bus
);
    localparam int MAX_A   = (INIT_WAIT_CYC > CLEAR_WAIT_CYC) ? INIT_WAIT_CYC : CLEAR_WAIT_CYC;
    localparam int MAX_B   = (CMD_WAIT_CYC > E_PULSE_CYC) ? CMD_WAIT_CYC : E_PULSE_CYC;
    localparam int MAX_C   = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] INIT_LAST   = CW'(INIT_WAIT_CYC - 1);
    localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EPULSE_LAST = CW'(E_PULSE_CYC - 1);
    localparam logic [CW-1:0] CMD_LAST    = CW'(CMD_WAIT_CYC - 1);
    localparam logic [CW-1:0] CLEAR_LAST  = CW'(CLEAR_WAIT_CYC - 1);

`ifdef LCD_PREFIX_EN
    localparam logic [2:0] LAST_CHAR = 3'd3;
`else
    localparam logic [2:0] LAST_CHAR = 3'd1;
`endif

    typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, CONV, WR_ADDR, WR_CHARS, DONE} state_t;
    typedef enum logic [1:0] {W_IDLE, W_SETUP, W_EPULSE, W_HOLD} wstate_t;

    state_t        state, state_n;
    wstate_t       wstate, wstate_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [5:0]    rem, rem_n;
    logic [2:0]    tens, tens_n;
    logic          rs_q, rs_n;
    logic [7:0]    data_q, data_n;
    logic          byte_end;

    function automatic logic [7:0] init_byte(input logic [2:0] i);
        case (i)
            3'd0:    return 8'h38;
            3'd1:    return 8'h0C;
            3'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [7:0] char_byte(input logic [2:0] i, input logic [2:0] t,
                                             input logic [5:0] o);
        logic [7:0] tens_ch;
        logic [7:0] ones_ch;
        tens_ch = 8'h30 + {5'b00000, t};
        ones_ch = 8'h30 + {2'b00, o};
`ifdef LCD_PREFIX_EN
        case (i)
            3'd0:    return 8'h52;
            3'd1:    return 8'h3D;
            3'd2:    return tens_ch;
            default: return ones_ch;
        endcase
`else
        return (i == 3'd0) ? tens_ch : ones_ch;
`endif
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= PWR_WAIT;
            wstate <= W_IDLE;
            cnt    <= '0;
            idx    <= '0;
            rem    <= '0;
            tens   <= '0;
            rs_q   <= 1'b0;
            data_q <= '0;
        end else begin
            state  <= state_n;
            wstate <= wstate_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            rem    <= rem_n;
            tens   <= tens_n;
            rs_q   <= rs_n;
            data_q <= data_n;
        end
    end

    // The byte writer times the current byte; the main FSM loads the next byte
    // in the same cycle the hold ends, so hold and setup phases abut exactly.
    always_comb begin
        state_n  = state;
        wstate_n = wstate;
        cnt_n    = cnt;
        idx_n    = idx;
        rem_n    = rem;
        tens_n   = tens;
        rs_n     = rs_q;
        data_n   = data_q;
        byte_end = 1'b0;

        case (wstate)
            W_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    wstate_n = W_EPULSE;
                    cnt_n    = '0;
                end else cnt_n = cnt + 1'b1;
            end
            W_EPULSE: begin
                if (cnt == EPULSE_LAST) begin
                    wstate_n = W_HOLD;
                    cnt_n    = '0;
                end else cnt_n = cnt + 1'b1;
            end
            W_HOLD: begin
                if (cnt == ((data_q == 8'h01) ? CLEAR_LAST : CMD_LAST)) begin
                    wstate_n = W_IDLE;
                    cnt_n    = '0;
                    byte_end = 1'b1;
                end else cnt_n = cnt + 1'b1;
            end
            default: ;
        endcase

        case (state)
            PWR_WAIT: begin
                if (cnt == INIT_LAST) begin
                    state_n  = INIT;
                    idx_n    = '0;
                    wstate_n = W_SETUP;
                    cnt_n    = '0;
                    rs_n     = 1'b0;
                    data_n   = init_byte(3'd0);
                end else cnt_n = cnt + 1'b1;
            end
            INIT: begin
                if (byte_end) begin
                    if (idx == 3'd3) state_n = IDLE;
                    else begin
                        idx_n    = idx + 3'd1;
                        wstate_n = W_SETUP;
                        data_n   = init_byte(idx + 3'd1);
                    end
                end
            end
            IDLE: begin
                if (bus.start) begin
                    rem_n   = bus.value;
                    tens_n  = '0;
                    state_n = CONV;
                end
            end
            // One subtraction of ten per cycle; rem ends holding the ones digit.
            CONV: begin
                if (rem >= 6'd10) begin
                    rem_n  = rem - 6'd10;
                    tens_n = tens + 3'd1;
                end else begin
                    state_n  = WR_ADDR;
                    wstate_n = W_SETUP;
                    cnt_n    = '0;
                    rs_n     = 1'b0;
                    data_n   = 8'h80;
                end
            end
            WR_ADDR: begin
                if (byte_end) begin
                    state_n  = WR_CHARS;
                    idx_n    = '0;
                    wstate_n = W_SETUP;
                    rs_n     = 1'b1;
                    data_n   = char_byte(3'd0, tens, rem);
                end
            end
            WR_CHARS: begin
                if (byte_end) begin
                    if (idx == LAST_CHAR) state_n = DONE;
                    else begin
                        idx_n    = idx + 3'd1;
                        wstate_n = W_SETUP;
                        data_n   = char_byte(idx + 3'd1, tens, rem);
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = PWR_WAIT;
        endcase
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.lcd_e    = (wstate == W_EPULSE);
    assign bus.lcd_rs   = rs_q;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_data = data_q;
endmodule

// File: tb/tb_lcd_result_writer.sv
// Directed bench for lcd_result_writer with shortened LCD timing.
// A negedge monitor records every E pulse (byte, RS, width, preceding low gap).
module tb_lcd_result_writer;
    localparam int INIT_WAIT_CYC  = 16;
    localparam int SETUP_CYC      = 1;
    localparam int E_PULSE_CYC    = 2;
    localparam int CMD_WAIT_CYC   = 4;
    localparam int CLEAR_WAIT_CYC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_result_writer_if bus();

    lcd_result_writer #(
        .INIT_WAIT_CYC (INIT_WAIT_CYC),
        .SETUP_CYC     (SETUP_CYC),
        .E_PULSE_CYC   (E_PULSE_CYC),
        .CMD_WAIT_CYC  (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         gap;
        int         width;
        bit         stable;
    } pulse_t;

    pulse_t pulses[$];
    pulse_t cur;
    int     low_cnt, high_cnt, done_cnt, done_gap, last_hold;
    logic   prev_e, prev_busy;
    int     n_vectors    = 0;
    int     n_miscompares = 0;

    // Gap counters restart on every E fall and on every busy rise.
    always @(negedge clk) begin
        if (rst) begin
            low_cnt   = 0;
            high_cnt  = 0;
            prev_e    = 1'b0;
            prev_busy = 1'b1;
        end else begin
            if (!prev_busy && bus.busy) low_cnt = 0;
            if (prev_busy && !bus.busy) last_hold = low_cnt;
            if (bus.done) begin
                done_cnt++;
                done_gap = low_cnt;
            end
            if (bus.lcd_e) begin
                if (!prev_e) begin
                    cur.data   = bus.lcd_data;
                    cur.rs     = bus.lcd_rs;
                    cur.gap    = low_cnt;
                    cur.stable = 1'b1;
                    cur.width  = 0;
                    high_cnt   = 0;
                end else if (bus.lcd_data !== cur.data || bus.lcd_rs !== cur.rs) begin
                    cur.stable = 1'b0;
                end
                high_cnt++;
            end else begin
                if (prev_e) begin
                    cur.width = high_cnt;
                    pulses.push_back(cur);
                    low_cnt = 0;
                end
                low_cnt++;
            end
            prev_e    = bus.lcd_e;
            prev_busy = bus.busy;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clearMonitor();
        pulses.delete();
        done_cnt  = 0;
        done_gap  = -1;
        last_hold = -1;
    endtask

    task automatic waitIdle(input int budget);
        int cyc = 0;
        while (bus.busy && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("idle_reached", 32'(bus.busy), 0);
        @(negedge clk);
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic checkInit();
        logic [7:0] exp_bytes [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
        checkOutput("init_count", pulses.size(), 4);
        for (int i = 0; i < pulses.size() && i < 4; i++) begin
            checkOutput($sformatf("init%0d_data", i), 32'(pulses[i].data), 32'(exp_bytes[i]));
            checkOutput($sformatf("init%0d_rs", i), 32'(pulses[i].rs), 0);
            checkOutput($sformatf("init%0d_width", i), pulses[i].width, E_PULSE_CYC);
            checkOutput($sformatf("init%0d_stable", i), 32'(pulses[i].stable), 1);
            checkOutput($sformatf("init%0d_gap", i), pulses[i].gap,
                        (i == 0) ? INIT_WAIT_CYC + SETUP_CYC : CMD_WAIT_CYC + SETUP_CYC);
        end
        checkOutput("init_clear_hold", last_hold, CLEAR_WAIT_CYC);
        checkOutput("init_no_done", done_cnt, 0);
        checkOutput("init_busy_low", 32'(bus.busy), 0);
    endtask

    task automatic applyStimulus(input logic [5:0] v, input logic [5:0] v_late, input bit extra_start);
        int cyc = 0;
        clearMonitor();
        @(negedge clk);
        bus.value = v;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput($sformatf("busy_rise_v%0d", v), 32'(bus.busy), 1);
        while (bus.busy && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 3) bus.value = v_late;
            if (cyc == 10 && extra_start) bus.start = 1'b1;
            if (cyc == 11) bus.start = 1'b0;
        end
        checkOutput($sformatf("update_end_v%0d", v), 32'(bus.busy), 0);
        @(negedge clk);
    endtask

    task automatic checkUpdate(input int v);
        logic [7:0] exp_q[$];
        logic       exp_rs[$];
        int         tens = v / 10;
        int         ones = v % 10;
        exp_q.push_back(8'h80);                exp_rs.push_back(1'b0);
`ifdef LCD_PREFIX_EN
        exp_q.push_back(8'h52);                exp_rs.push_back(1'b1);
        exp_q.push_back(8'h3D);                exp_rs.push_back(1'b1);
`endif
        exp_q.push_back(8'(8'h30 + tens));     exp_rs.push_back(1'b1);
        exp_q.push_back(8'(8'h30 + ones));     exp_rs.push_back(1'b1);
        checkOutput($sformatf("v%0d_count", v), pulses.size(), exp_q.size());
        for (int i = 0; i < pulses.size() && i < exp_q.size(); i++) begin
            checkOutput($sformatf("v%0d_b%0d_data", v, i), 32'(pulses[i].data), 32'(exp_q[i]));
            checkOutput($sformatf("v%0d_b%0d_rs", v, i), 32'(pulses[i].rs), 32'(exp_rs[i]));
            checkOutput($sformatf("v%0d_b%0d_width", v, i), pulses[i].width, E_PULSE_CYC);
            checkOutput($sformatf("v%0d_b%0d_stable", v, i), 32'(pulses[i].stable), 1);
            if (i == 0)
                checkOutput($sformatf("v%0d_conv_cycles", v), pulses[i].gap - SETUP_CYC, tens + 1);
            else
                checkOutput($sformatf("v%0d_b%0d_gap", v, i), pulses[i].gap, CMD_WAIT_CYC + SETUP_CYC);
        end
        checkOutput($sformatf("v%0d_done_count", v), done_cnt, 1);
        checkOutput($sformatf("v%0d_done_after_hold", v), done_gap, CMD_WAIT_CYC);
        checkOutput($sformatf("v%0d_busy_after_done", v), last_hold, CMD_WAIT_CYC + 1);
        checkOutput($sformatf("v%0d_rw", v), 32'(bus.lcd_rw), 0);
    endtask

    initial begin
        int cyc;
        bus.start = 1'b0;
        bus.value = 6'd0;
        clearMonitor();

        // Reset state, then power-on init with an ignored start in the middle
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(bus.busy), 1);
        checkOutput("rst_e", 32'(bus.lcd_e), 0);
        checkOutput("rst_rs", 32'(bus.lcd_rs), 0);
        checkOutput("rst_data", 32'(bus.lcd_data), 0);
        checkOutput("rst_rw", 32'(bus.lcd_rw), 0);
        checkOutput("rst_done", 32'(bus.done), 0);
        releaseReset();
        repeat (20) @(negedge clk);
        bus.value = 6'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waitIdle(500);
        checkInit();

        // 42 with a late value change and a start during the update
        applyStimulus(6'd42, 6'd17, 1'b1);
        checkUpdate(42);

        // Digit boundaries
        applyStimulus(6'd0, 6'd0, 1'b0);
        checkUpdate(0);
        applyStimulus(6'd9, 6'd9, 1'b0);
        checkUpdate(9);
        applyStimulus(6'd10, 6'd10, 1'b0);
        checkUpdate(10);
        applyStimulus(6'd63, 6'd63, 1'b0);
        checkUpdate(63);

        // Reset while E is high for the tens digit
        clearMonitor();
        @(negedge clk);
        bus.value = 6'd42;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
`ifdef LCD_PREFIX_EN
        while (!(pulses.size() == 3 && bus.lcd_e) && cyc < 200) begin
`else
        while (!(pulses.size() == 1 && bus.lcd_e) && cyc < 200) begin
`endif
            @(negedge clk);
            cyc++;
        end
        checkOutput("abort_e_high", 32'(bus.lcd_e), 1);
        checkOutput("abort_tens_byte", 32'(bus.lcd_data), 32'h34);
        #1 rst = 1'b1;
        #1;
        checkOutput("abort_e_low", 32'(bus.lcd_e), 0);
        checkOutput("abort_data_zero", 32'(bus.lcd_data), 0);
        checkOutput("abort_busy", 32'(bus.busy), 1);
        checkOutput("abort_rs_zero", 32'(bus.lcd_rs), 0);
        repeat (3) @(negedge clk);
        clearMonitor();
        releaseReset();
        waitIdle(500);
        checkInit();

        // Single-digit value after re-init (shows "R=05" with the prefix build)
        applyStimulus(6'd5, 6'd5, 1'b0);
        checkUpdate(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule

// File: doc/lcd_result_writer.md
Name: lcd_result_writer

Overview:
Downstream consumer of the 6-bit exponent result register. It drives an HD44780-compatible character LCD in 8-bit write-only mode.
- After reset it runs the LCD power-on initialisation.
- On each `start` pulse it converts the 6-bit value to two decimal ASCII digits and writes them at line 1, column 0.
- It is the display-side stage between the datapath/controller and the LCD pins.

Parameters:
INIT_WAIT_CYC, 750000, idle cycles after reset before the first init command.
SETUP_CYC, 2, cycles RS/DATA are stable with E low before the E pulse.
E_PULSE_CYC, 12, cycles E is held high per byte.
CMD_WAIT_CYC, 2500, cycles after E falls before the next byte (all bytes except clear).
CLEAR_WAIT_CYC, 100000, post-E wait after the clear command 0x01.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to display `value`; sampled only in IDLE
value  in  6  unsigned result to display (0..63)
busy  out  1  high whenever not in IDLE
done  out  1  one-cycle pulse when the display update completes
lcd_rs  out  1  0 = command, 1 = character data
lcd_rw  out  1  tied 0 (write only)
lcd_e  out  1  LCD enable strobe
lcd_data  out  8  LCD data bus

Behaviour:
- Reset (asynchronous, immediate): lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, done=0, busy=1. All counters clear and the FSM goes to PWR_WAIT.
- Reset mid-write aborts the byte (E drops at once). Init restarts after release.
- Byte writer sub-FSM, used for every byte:
  - W_SETUP: SETUP_CYC cycles, E=0, RS/DATA driven.
  - W_EPULSE: E_PULSE_CYC cycles, E=1.
  - W_HOLD: CMD_WAIT_CYC cycles (CLEAR_WAIT_CYC if the byte is 0x01), E=0.
  - RS/DATA stay stable through all three phases and keep their last values afterwards.
- Main FSM:
  - PWR_WAIT: count INIT_WAIT_CYC cycles, then go to INIT.
  - INIT: write commands 0x38, 0x0C, 0x06, 0x01 in order (RS=0), then go to IDLE.
  - IDLE: busy=0. On start=1, latch value into an internal register and go to CONV. busy rises the cycle after start is sampled.
  - CONV: repeated subtraction, one step per cycle:
    - If rem ≥ 10: rem -= 10, tens += 1.
    - Otherwise go to WR_ADDR.
    - Takes tens+1 cycles; tens is at most 6.
  - WR_ADDR: write 0x80 (RS=0).
  - WR_CHARS: write 0x30+tens, then 0x30+ones (RS=1). The leading zero is always shown.
  - DONE: done=1 for exactly one cycle, then IDLE. busy=0 from IDLE entry.
- start is ignored outside IDLE, including during init. No queuing.
- Changes on `value` after it is latched have no effect on the current update.
- lcd_rw is 0 in all states.
- Counters are sized for the largest parameter; a parameter value of 0 is illegal.

Optional Feature:
LCD_PREFIX_EN
- Defined: after the 0x80 command and before the digits, write 'R' (0x52) then '=' (0x3D) with RS=1. The display shows "R=dd".
- Undefined: only the two digits are written; the prefix logic is not compiled.

Test Plan (bench overrides: INIT_WAIT_CYC=16, SETUP_CYC=1, E_PULSE_CYC=2, CMD_WAIT_CYC=4, CLEAR_WAIT_CYC=8):
1. Release reset -> E stays low 16 cycles. Then four E pulses, each 2 cycles high, with RS=0 and data 0x38, 0x0C, 0x06, 0x01. Gap after 0x01 is 8 cycles. busy falls after that; done never pulses.
2. In IDLE, start with value=42 -> E pulses carry 0x80 (RS=0), then 0x34 and 0x32 (RS=1). done is high exactly 1 cycle after the last hold; busy=0 next.
3. Boundary values: value=0 -> 0x30,0x30; value=9 -> 0x30,0x39; value=10 -> 0x31,0x30; value=63 -> 0x36,0x33. CONV takes 1, 1, 2 and 7 cycles respectively.
4. Ignored requests:
   - start during init -> no extra writes.
   - start during an update -> no extra writes.
   - value changed 42→17 mid-update -> digits still 0x34,0x32.
5. rst asserted during W_EPULSE of the tens digit -> lcd_e=0, data=0x00 and busy=1 immediately. After release, the full init sequence from test 1 repeats.
6. LCD_PREFIX_EN defined, value=5 -> bytes 0x80, 0x52, 0x3D, 0x30, 0x35; RS pattern 0,1,1,1,1.
